// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches over req/gnt/rvalid,
// buffers returned words in a small prefetch queue and redirects on a consumed taken branch.
module instr_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] PCPlus8,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;

    logic [31:0]     q_data_q [DEPTH];
    logic [31:0]     q_tag_q  [DEPTH];
    logic [AW-1:0]   q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [CW-1:0]   q_cnt_q, q_cnt_d;

    logic [31:0]     t_fifo_q [DEPTH];
    logic [AW-1:0]   t_head_q, t_head_d, t_tail_q, t_tail_d;

    logic issue, grant, rsp, pop, redirect, push, tpush;

    // Budget counts in-flight plus buffered words so a response always has a slot.
    assign issue    = (state_q == RUN) && (({1'b0, outst_q} + {1'b0, q_cnt_q}) < DEPTH_C);
    assign grant    = issue && imem_gnt;
    assign rsp      = imem_rvalid && (outst_q != '0);
    assign pop      = instr_valid && instr_ready;
    assign redirect = pop && PCSrc;
    assign push     = rsp && (state_q == RUN) && !redirect;
    assign tpush    = grant && !redirect;

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (q_cnt_q != '0);
    assign Instr       = instr_valid ? q_data_q[q_head_q] : 32'h0;
    assign PCPlus8     = instr_valid ? (q_tag_q[q_head_q] + 32'd8) : 32'h0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(grant) - CW'(rsp);
        q_head_d   = q_head_q;
        q_tail_d   = q_tail_q;
        q_cnt_d    = q_cnt_q;
        t_head_d   = t_head_q;
        t_tail_d   = t_tail_q;

        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;

        if (redirect) begin
            fetch_pc_d = PCTarget & 32'hFFFF_FFFC;
            q_head_d   = '0;
            q_tail_d   = '0;
            q_cnt_d    = '0;
            t_head_d   = '0;
            t_tail_d   = '0;
        end else begin
            if (push) q_tail_d = q_tail_q + 1'b1;
            if (pop)  q_head_d = q_head_q + 1'b1;
            q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
            if (tpush) t_tail_d = t_tail_q + 1'b1;
            if (push)  t_head_d = t_head_q + 1'b1;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect && (outst_d != '0)) state_d = DRAIN;
            DRAIN:   if (outst_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            q_cnt_q    <= '0;
            t_head_q   <= '0;
            t_tail_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            q_cnt_q    <= q_cnt_d;
            t_head_q   <= t_head_d;
            t_tail_q   <= t_tail_d;
        end
    end

    // Storage needs no reset: occupancy and pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data_q[q_tail_q] <= imem_rdata;
            q_tag_q[q_tail_q]  <= t_fifo_q[t_head_q];
        end
        if (tpush) t_fifo_q[t_tail_q] <= fetch_pc_q;
    end

endmodule
